// File: rtl/cv32e40p_apu_iter_unit.sv
// cv32e40p_apu_iter_unit: APU responder with fast integer ops and a 32-step shift-add multiplier
module cv32e40p_apu_iter_unit #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int FAST_LATENCY     = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 apu_req_i,
  output logic                                 apu_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]       apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]               apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]          apu_flags_i,
  output logic                                 apu_rvalid_o,
  output logic [31:0]                          apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]          apu_flags_o
);
  typedef enum logic [1:0] {IDLE, BUSY_FAST, BUSY_MUL} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] step_q, step_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d, res_q, res_d;
  logic [4:0] flg_q, flg_d;
  logic hi_q, hi_d, rvalid_q, rvalid_d;
  logic [31:0] a, b, c, sum, dif, fres;
  logic [4:0] fflg;
  logic [5:0] op;
  logic [32:0] madd;
  logic is_mul, ovf_add, ovf_sub;
  logic unused_flags;
  assign unused_flags = ^apu_flags_i;
  assign a = apu_operands_i[0];
  assign b = apu_operands_i[1];
  assign c = apu_operands_i[2];
  assign op = apu_op_i[5:0];
  assign sum = a + b;
  assign dif = a - b;
  assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
  assign ovf_sub = (a[31] != b[31]) && (dif[31] != a[31]);
  assign is_mul = (op == 6'd3) || (op == 6'd4);
  assign fres = op == 6'd0 ? sum : op == 6'd1 ? dif : op == 6'd2 ? sum + c : 32'd0;
  assign fflg = op == 6'd0 ? {2'b0, ovf_add, 2'b0} : op == 6'd1 ? {2'b0, ovf_sub, 2'b0} :
                op == 6'd2 ? 5'b0 : 5'b10000;
  // the single multiplier adder: upper accumulator half plus a when the current b bit is set
  assign madd = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? a_q : 32'd0};
  assign apu_rvalid_o = rvalid_q;
  assign apu_result_o = rvalid_q ? res_q : 32'd0;
  assign apu_flags_o = rvalid_q ? APU_NUSFLAGS_CPU'(flg_q) : '0;
  // next state: grant only in IDLE; FAST_LATENCY=1 answers straight from the grant cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    step_d = step_q;
    acc_d = acc_q;
    a_d = a_q;
    res_d = res_q;
    flg_d = flg_q;
    hi_d = hi_q;
    rvalid_d = 1'b0;
    apu_gnt_o = rst_ni && apu_req_i && (state_q == IDLE);
    case (state_q)
      IDLE: if (apu_gnt_o) begin
        a_d = a;
        hi_d = op == 6'd4;
        if (is_mul) begin
          state_d = BUSY_MUL;
          acc_d = {32'd0, b};
          step_d = 6'd0;
        end else begin
          res_d = fres;
          flg_d = fflg;
          cnt_d = 4'(FAST_LATENCY - 1);
          rvalid_d = FAST_LATENCY == 1;
          state_d = FAST_LATENCY == 1 ? IDLE : BUSY_FAST;
        end
      end
      BUSY_FAST: begin
        cnt_d = cnt_q - 4'd1;
        rvalid_d = cnt_q == 4'd1;
        state_d = cnt_q == 4'd1 ? IDLE : BUSY_FAST;
      end
      BUSY_MUL: begin
        acc_d = {madd, acc_q[31:1]};
        step_d = step_q + 6'd1;
        if (step_q == 6'd31) begin
          rvalid_d = 1'b1;
          res_d = hi_q ? madd[32:1] : {madd[0], acc_q[31:1]};
          flg_d = 5'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any pending operation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      step_q <= 6'd0;
      acc_q <= 64'd0;
      a_q <= 32'd0;
      res_q <= 32'd0;
      flg_q <= 5'd0;
      hi_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      acc_q <= acc_d;
      a_q <= a_d;
      res_q <= res_d;
      flg_q <= flg_d;
      hi_q <= hi_d;
      rvalid_q <= rvalid_d;
    end
  end
endmodule
